// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter that shares the SDRAM controller's single
// internal port between NUM_PORTS requesters (e.g. CPU ibus, CPU dbus, DMA).
// Lives in the sdram_clk domain, between the requester bus adapters and the
// controller. A grant is held across back-to-back accesses so open-row hits
// stay fast, and is forcibly released after HOLD_ACKS acks when others wait.
//
// Ports:
//   sdram_clk, sdram_rst      clock, synchronous active-high reset
//   m_acc_i/m_we_i            per-port request / write enable (acc held until ack)
//   m_adr_i/m_dat_i/m_sel_i   per-port address (32b), write data (16b), selects (2b)
//   m_ack_o                   per-port ack (only ever the granted port)
//   m_dat_o/m_adr_o           controller read data/address, broadcast to all ports
//   s_acc_o..s_sel_o          muxed request to the controller
//   s_ack_i/s_dat_i/s_adr_i   controller ack, read data, read-data address
//   grant_o                   one-hot current grant, 0 when idle
module sdram_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int HOLD_ACKS = 16
) (
  input  logic                    sdram_clk,
  input  logic                    sdram_rst,
  input  logic [NUM_PORTS-1:0]    m_acc_i,
  input  logic [NUM_PORTS-1:0]    m_we_i,
  input  logic [32*NUM_PORTS-1:0] m_adr_i,
  input  logic [16*NUM_PORTS-1:0] m_dat_i,
  input  logic [2*NUM_PORTS-1:0]  m_sel_i,
  output logic [NUM_PORTS-1:0]    m_ack_o,
  output logic [15:0]             m_dat_o,
  output logic [31:0]             m_adr_o,
  output logic                    s_acc_o,
  output logic                    s_we_o,
  output logic [31:0]             s_adr_o,
  output logic [15:0]             s_dat_o,
  output logic [1:0]              s_sel_o,
  input  logic                    s_ack_i,
  input  logic [15:0]             s_dat_i,
  input  logic [31:0]             s_adr_i,
  output logic [NUM_PORTS-1:0]    grant_o
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state, state_nxt;
  logic [NUM_PORTS-1:0]   grant, grant_nxt;
  logic [IW-1:0]          rr_ptr, rr_nxt;
  logic [7:0]             hold_cnt, hold_nxt;
  logic                   rel_r, rel_nxt;

  logic [2*NUM_PORTS-1:0] rot;
  logic                   pick_vld;
  logic [IW-1:0]          pick_idx;
  logic [IW:0]            sum;
  logic [IW-1:0]          g_idx;
  logic                   own_acc;
  logic                   others_wait;

  // Round-robin scan: rotate the request vector so rr_ptr lands at bit 0,
  // then take the lowest set bit. Scanning downward leaves the lowest match.
  always_comb begin
    rot      = {m_acc_i, m_acc_i} >> rr_ptr;
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, rr_ptr} + (IW+1)'(i);
        if (sum >= (IW+1)'(NUM_PORTS)) sum = sum - (IW+1)'(NUM_PORTS);
        pick_vld = 1'b1;
        pick_idx = sum[IW-1:0];
      end
    end
  end

  // Request mux from the granted port; all zero while idle (grant == 0).
  always_comb begin
    g_idx   = '0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (grant[k]) begin
        g_idx   = IW'(k);
        s_we_o  = m_we_i[k];
        s_adr_o = m_adr_i[32*k +: 32];
        s_dat_o = m_dat_i[16*k +: 16];
        s_sel_o = m_sel_i[2*k +: 2];
      end
    end
  end

  assign own_acc     = |(m_acc_i & grant);
  assign others_wait = |(m_acc_i & ~grant);
  assign s_acc_o     = (state == GRANT) & own_acc & ~rel_r;
  assign m_ack_o     = (state == GRANT) ? (grant & {NUM_PORTS{s_ack_i}}) : '0;
  assign m_dat_o     = s_dat_i;
  assign m_adr_o     = s_adr_i;
  assign grant_o     = grant;

  // Releases happen only on an acc-low cycle or an ack cycle, so the
  // controller never has an access in flight when the grant moves.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    hold_nxt  = hold_cnt;
    rel_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = GRANT;
          grant_nxt = NUM_PORTS'(1) << pick_idx;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (s_ack_i && (hold_cnt != 8'(HOLD_ACKS))) hold_nxt = hold_cnt + 8'd1;
        if (!own_acc || rel_r) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          rr_nxt    = (g_idx == IW'(NUM_PORTS - 1)) ? '0 : g_idx + 1'b1;
        end else if (s_ack_i && (hold_cnt == 8'(HOLD_ACKS - 1)) && others_wait) begin
          // Forced release: the holder re-competes from behind everyone else.
          state_nxt = IDLE;
          grant_nxt = '0;
          rr_nxt    = (g_idx == IW'(NUM_PORTS - 1)) ? '0 : g_idx + 1'b1;
          rel_nxt   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      rel_r    <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_nxt;
      hold_cnt <= hold_nxt;
      rel_r    <= rel_nxt;
    end
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Round-robin arbiter that shares the single SDRAM controller internal port (acc/we/adr/dat/sel in, ack/adr/dat out) between NUM_PORTS requesters, such as CPU ibus, CPU dbus and DMA.
- It sits between the requester-side bus adapters and the SDRAM controller, in the sdram_clk domain.
- A grant is held across back-to-back accesses from one requester, so open-row hits stay fast.
- A grant is forcibly released after HOLD_ACKS acks when other requesters are waiting.

Parameters:
NUM_PORTS, 3, number of requesters (2..8)
HOLD_ACKS, 16, acks a grant may absorb before forced release while others wait (1..255)

Ports:
sdram_clk  in  1  clock
sdram_rst  in  1  synchronous active-high reset
m_acc_i  in  NUM_PORTS  per-port access request; held until that port's ack
m_we_i  in  NUM_PORTS  per-port write enable
m_adr_i  in  32*NUM_PORTS  per-port byte address; port k at [32k+31:32k]
m_dat_i  in  16*NUM_PORTS  per-port write data
m_sel_i  in  2*NUM_PORTS  per-port byte selects
m_ack_o  out  NUM_PORTS  per-port ack
m_dat_o  out  16  read data, broadcast to all ports
m_adr_o  out  32  address of m_dat_o, broadcast
s_acc_o  out  1  request to controller
s_we_o  out  1  write enable to controller
s_adr_o  out  32  address to controller
s_dat_o  out  16  write data to controller
s_sel_o  out  2  byte selects to controller
s_ack_i  in  1  controller ack
s_dat_i  in  16  controller read data
s_adr_i  in  32  controller read-data address
grant_o  out  NUM_PORTS  one-hot current grant, 0 when idle

Behaviour:
- Reset values:
  - state=IDLE, grant_o=0, rr_ptr=0, hold_cnt=0.
  - s_acc_o=0.
  - m_ack_o=0.
  - s_we_o/s_adr_o/s_dat_o/s_sel_o are don't-care but driven 0 while idle.
- States: IDLE and GRANT.
- IDLE:
  - If any m_acc_i is set, pick the first requesting port scanning upward from rr_ptr (wrapping).
  - Register it in grant_o and go to GRANT; hold_cnt=0.
  - s_acc_o stays 0 in IDLE, so arbitration latency is 1 cycle.
- GRANT, port g:
  - s_acc_o = m_acc_i[g] & ~rel_r.
  - s_we_o/s_adr_o/s_dat_o/s_sel_o are combinational muxes of port g.
  - m_ack_o[g] = s_ack_i; all other m_ack_o bits are 0.
- m_dat_o=s_dat_i and m_adr_o=s_adr_i in all states; requesters qualify them with their own ack.
- hold_cnt counts s_ack_i in GRANT and saturates at HOLD_ACKS.
- Release A: m_acc_i[g]=0 in GRANT -> IDLE, rr_ptr=(g+1) mod NUM_PORTS, grant_o=0.
- Release B (forced): s_ack_i=1 and hold_cnt==HOLD_ACKS-1 and any other m_acc_i set.
  - Set rel_r, so s_acc_o=0 from the next cycle.
  - Next cycle -> IDLE, rr_ptr=g+1.
  - Port g re-competes; it is served again after every other waiting port gets one grant.
- Without other waiters the grant is held indefinitely; hold_cnt saturates.
- Release is only taken on an ack cycle or an acc-low cycle. Requesters must hold acc until ack, so no access is outstanding at release.
- An ack never reaches a non-granted port.
- A simultaneous new request from the releasing port on the release cycle is ignored until the next IDLE scan.
- sdram_rst mid-transfer: immediate return to IDLE and reset values; the controller is reset by the same signal.

Test Plan:
- Single port 1 requests a write to 0x00000100, dat 0xBEEF, sel 2'b11 -> 1 idle cycle; then s_acc_o=1 with s_adr_o=0x100, s_dat_o=0xBEEF; m_ack_o=3'b010 on controller ack; grant_o=0 once acc drops.
- Ports 0, 1, 2 all request continuously after reset, one ack each then drop acc -> grant order 0,1,2; then 0 first again; no ack on a non-granted port.
- Port 0 streams 40 reads and port 2 requests at ack 5, HOLD_ACKS=16 -> port 0 released after its 16th ack; s_acc_o low for one cycle; port 2 granted next; port 0 regranted after port 2 drops.
- Port 0 streams 40 reads alone -> grant never released; s_acc_o never drops between acks.
- Read from port 2: controller returns s_dat_i=0x1234, s_adr_i=0x2000 with ack -> m_dat_o=0x1234, m_adr_o=0x2000, m_ack_o=3'b100 in the same cycle.
- sdram_rst asserted while port 1 is granted with s_acc_o=1 -> next cycle grant_o=0, s_acc_o=0, m_ack_o=0; after reset the first arbitration starts scanning at port 0.
